// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: moves an N-bit operand one position per clock, either as a
// zero-fill shift or a rotate in either direction, and posts the result with a done pulse.
module shift_sequencer #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [N-1:0]         A,
  input  logic [$clog2(N)-1:0] B,
  input  logic                 sel,
  input  logic                 dir,
  output logic                 busy,
  output logic                 done,
  output logic [N-1:0]         Aout
);

  localparam int W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [N-1:0]   work, work_n;
  logic [W-1:0]   count, count_n;
  logic           sel_q, sel_n;
  logic           dir_q, dir_n;
  logic [N-1:0]   aout_q, aout_n;
  logic [N-1:0]   shifted;

  // One-position move of the work register using the captured mode bits.
  always_comb begin
    shifted = work;
    case ({sel_q, dir_q})
      2'b00:   shifted = {work[N-2:0], 1'b0};
      2'b01:   shifted = {1'b0, work[N-1:1]};
      2'b10:   shifted = {work[N-2:0], work[N-1]};
      default: shifted = {work[0], work[N-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      count  <= '0;
      sel_q  <= 1'b0;
      dir_q  <= 1'b0;
      aout_q <= '0;
    end else begin
      state  <= state_n;
      work   <= work_n;
      count  <= count_n;
      sel_q  <= sel_n;
      dir_q  <= dir_n;
      aout_q <= aout_n;
    end
  end

  always_comb begin
    state_n = state;
    work_n  = work;
    count_n = count;
    sel_n   = sel_q;
    dir_n   = dir_q;
    aout_n  = aout_q;
    case (state)
      IDLE: begin
        // start outranks abort here; abort has nothing to cancel in IDLE.
        if (start) begin
          work_n  = A;
          count_n = B;
          sel_n   = sel;
          dir_n   = dir;
          if (B == '0) begin
            state_n = DONE;
            aout_n  = A;
          end else begin
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          work_n  = shifted;
          count_n = count - 1'b1;
          if (count == W'(1)) begin
            state_n = DONE;
            aout_n  = shifted;
          end
        end
      end
      DONE: begin
        // Always one cycle here; start/abort during this cycle are ignored.
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign Aout = aout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios plus randomized
// operations checked cycle by cycle against an arithmetic reference model.
module tb_shift_sequencer;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [N-1:0] A;
  logic [W-1:0] B;
  logic         sel;
  logic         dir;
  logic         busy;
  logic         done;
  logic [N-1:0] Aout;

  int checks;
  int failures;
  logic [N-1:0] prev_aout;

  shift_sequencer #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .A     (A),
    .B     (B),
    .sel   (sel),
    .dir   (dir),
    .busy  (busy),
    .done  (done),
    .Aout  (Aout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: whole-operand shift/rotate by b positions.
  function automatic logic [N-1:0] model(input logic [N-1:0] a, input int b,
                                         input logic s, input logic d);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   res;
    dbl = {a, a};
    if (!s) begin
      res = d ? (a >> b) : (a << b);
    end else if (d) begin
      dbl = dbl >> b;
      res = dbl[N-1:0];
    end else begin
      dbl = dbl << b;
      res = dbl[2*N-1:N];
    end
    return res;
  endfunction

  // Driver + per-cycle checker for one operation.
  // abort_at: cycle index (after the start edge) on which abort is driven, -1 for none.
  // noise: scramble inputs and pulse start/abort where they must have no effect.
  task automatic run_op(input logic [N-1:0] a, input int b, input logic s, input logic d,
                        input int abort_at, input bit noise);
    logic [N-1:0] exp;
    bit aborting;
    int last;
    exp      = model(a, b, s, d);
    aborting = (abort_at >= 0) && (abort_at < b);
    last     = aborting ? abort_at + 1 : b + 1;
    A     = a;
    B     = W'(b);
    sel   = s;
    dir   = d;
    start = 1'b1;
    abort = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    for (int c = 0; c <= last; c++) begin
      if (aborting) begin
        check("abort_busy", busy, (c <= abort_at) ? 1 : 0);
        check("abort_done", done, 0);
        check("abort_aout", Aout, prev_aout);
      end else if (c < b) begin
        check("run_busy", busy, 1);
        check("run_done", done, 0);
        check("run_aout", Aout, prev_aout);
      end else if (c == b) begin
        check("done_busy", busy, 1);
        check("done_pulse", done, 1);
        check("done_aout", Aout, exp);
        prev_aout = exp;
      end else begin
        check("post_busy", busy, 0);
        check("post_done", done, 0);
        check("post_aout", Aout, prev_aout);
      end
      start = 1'b0;
      abort = 1'b0;
      if (noise && c < last) begin
        A     = N'($urandom);
        B     = W'($urandom);
        sel   = 1'($urandom);
        dir   = 1'($urandom);
        start = 1'($urandom_range(0, 1));
        if (!aborting && c == b) abort = 1'($urandom_range(0, 1));
      end
      if (aborting && c == abort_at) abort = 1'b1;
      if (c < last) tick();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    prev_aout = '0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    A = '0;
    B = '0;
    sel = 1'b0;
    dir = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_aout", Aout, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Directed scenarios
    run_op(8'b1001_0110, 3, 1'b0, 1'b0, -1, 1'b0);
    check("lsl3_value", Aout, 8'b1011_0000);
    run_op(8'b1001_0110, 3, 1'b1, 1'b1, -1, 1'b0);
    check("ror3_value", Aout, 8'b1101_0010);
    run_op(8'h81, 0, 1'b0, 1'b0, -1, 1'b0);
    run_op(8'h0F, 5, 1'b0, 1'b0, 1, 1'b0);
    check("abort_keeps", Aout, 8'h81);
    run_op(8'hFF, 7, 1'b0, 1'b1, -1, 1'b1);
    check("lsr7_value", Aout, 8'h01);
    run_op(8'hA5, 7, 1'b1, 1'b0, -1, 1'b1);
    run_op(8'h3C, 4, 1'b1, 1'b1, 0, 1'b1);

    // Reset in the middle of a shift
    run_op(8'h5A, 2, 1'b0, 1'b0, -1, 1'b0);
    A = 8'h0F;
    B = W'(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_aout", Aout, 0);
    prev_aout = '0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
    end
    run_op(8'h01, 1, 1'b0, 1'b0, -1, 1'b0);
    check("after_rst_value", Aout, 8'h02);

    // First edge after reset release accepts start
    #2;
    rst_n = 1'b0;
    prev_aout = '0;
    tick();
    rst_n = 1'b1;
    run_op(8'hC3, 2, 1'b1, 1'b0, -1, 1'b0);

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      int b;
      int ab;
      b  = $urandom_range(0, N - 1);
      ab = -1;
      if (b > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(0, b - 1);
      run_op(N'($urandom), b, 1'($urandom), 1'($urandom), ab, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, data width in bits; legal values are powers of two with N >= 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin one shift operation.
REQ-005 SHALL have port abort, input, 1 bit: synchronous cancel of an operation in progress.
REQ-006 SHALL have port A, input, N bits: operand.
REQ-007 SHALL have port B, input, $clog2(N) bits: shift amount, 0..N-1.
REQ-008 SHALL have port sel, input, 1 bit: 0 = logical shift with zero fill, 1 = rotate.
REQ-009 SHALL have port dir, input, 1 bit: 0 = left (toward MSB), 1 = right (toward LSB).
REQ-010 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port Aout, output, N bits: registered result of the last completed operation.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-014 In IDLE, start=1 at a rising edge SHALL capture A into a work register, and B, sel and dir into internal registers.
- B=0 -> next state DONE.
- B>0 -> next state SHIFT, with the count register loaded with B.
REQ-015 In SHIFT, each rising edge SHALL move the work register exactly one position per the captured sel and dir, and decrement the count; the shift that takes the count to 0 also moves the FSM to DONE.
REQ-016 The one-position shift SHALL be:
- logical left: {w[N-2:0],0}
- logical right: {0,w[N-1:1]}
- rotate left: {w[N-2:0],w[N-1]}
- rotate right: {w[0],w[N-1:1]}
REQ-017 On the edge that enters DONE, Aout SHALL be loaded with the final work value; no other edge changes Aout, except reset (REQ-025).
REQ-018 done SHALL be 1 for exactly the one cycle spent in DONE; the FSM SHALL return to IDLE on the next edge.
REQ-019 Latency: with start sampled at edge t0, done SHALL be high in the cycle following edge t0+B (B=0 gives done in the cycle right after t0); busy is high from t0 through the DONE cycle.
REQ-020 start while busy=1 (SHIFT or DONE) SHALL be ignored and not queued; A, B, sel and dir changes during an operation SHALL have no effect.
REQ-021 start sampled in the same cycle that DONE exits SHALL be ignored; back-to-back operations therefore have at least one IDLE cycle between them.
REQ-022 abort=1 in SHIFT SHALL force IDLE on the next edge, with no done pulse and Aout unchanged (previous result kept).
REQ-023 abort=1 in DONE SHALL have no effect; done still pulses and Aout is already updated. abort in IDLE SHALL be ignored.
REQ-024 abort and start both high in IDLE: start SHALL take effect.

Reset
REQ-025 While rst_n=0, asynchronously and independent of clk: state=IDLE, work, count and Aout = 0, busy=0, done=0.
REQ-026 rst_n asserted mid-operation SHALL discard the operation; after release the block SHALL idle until a new start, with no spurious done.
REQ-027 The first rising edge after rst_n deasserts SHALL accept start normally.

Verification (N=8)
REQ-028 A=8'b1001_0110, B=3, sel=0, dir=0, start one cycle -> busy for 4 cycles, done in cycle after t0+3, Aout=8'b1011_0000.
REQ-029 A=8'b1001_0110, B=3, sel=1, dir=1 -> Aout=8'b1101_0010; then A=8'h81, B=0 -> done in cycle after t0, Aout=8'h81.
REQ-030 A=8'hFF, B=7, sel=0, dir=1 -> Aout=8'h01, done after t0+7; start pulses during busy are ignored (single done, Aout unchanged by them).
REQ-031 After Aout=8'h81, start A=8'h0F, B=5, then abort at second SHIFT cycle -> busy drops next edge, no done, Aout stays 8'h81.
REQ-032 rst_n low in mid-SHIFT -> immediately busy=0, done=0, Aout=0; no done after release; a subsequent start with A=8'h01, B=1, sel=0, dir=0 -> Aout=8'h02.
